// File: rtl/picc_tx_scheduler.sv
// Frame scheduler for a PICC transmitter: assembles up to 5 stream bytes per frame,
// buffers one pending frame, then triggers the transmitter and enforces done-timeout and guard time.
//
//  state     | meaning
//  IDLE      | waiting for a pending frame; loads transmit registers
//  TRIG      | issuing the one-cycle trigger once the transmitter is not busy
//  WAIT_DONE | waiting for done pulse or timeout
//  GUARD     | idle gap between frames, done pulses ignored
module picc_tx_scheduler #(
    parameter int GUARD_CYCLES   = 1024,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic        s00_axis_aclk,
    input  logic        s00_axis_aresetn,
    input  logic        s00_axis_tvalid,
    input  logic [7:0]  s00_axis_tdata,
    input  logic        s00_axis_tlast,
    output logic        s00_axis_tready,
    output logic [39:0] picc_data_out,
    output logic [2:0]  picc_num_bytes_out,
    output logic        picc_trigger_out,
    input  logic        picc_busy_in,
    input  logic        picc_done_in,
    output logic        tx_active,
    output logic [15:0] frames_sent,
    output logic        err_overlen,
    output logic        err_timeout,
    input  logic        err_clear
);

    localparam int GW = $clog2(GUARD_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [GW-1:0] GUARD_LOAD   = GW'(GUARD_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, TRIG, WAIT_DONE, GUARD} state_t;
    state_t state, state_next;

    logic          ready_en;
    logic          asm_full;
    logic          asm_drop;
    logic [39:0]   asm_data;
    logic [2:0]    asm_cnt;
    logic          pend_valid;
    logic [39:0]   pend_data;
    logic [2:0]    pend_num;
    logic [TW-1:0] tmo_cnt;
    logic [GW-1:0] grd_cnt;
    logic          beat;
    logic          move;
    logic          overlen_hit;
    logic          load_tx;
    logic          fire;
    logic          done_ok;
    logic          tmo_hit;

    // ready_en holds tready low until the first edge after reset release
    assign s00_axis_tready  = ready_en & ~asm_full;
    assign beat             = s00_axis_tvalid & s00_axis_tready;
    assign move             = asm_full & ~pend_valid;
    assign overlen_hit      = beat & ~asm_drop & (asm_cnt == 3'd5);
    assign picc_trigger_out = fire;
    assign tx_active        = (state != IDLE);

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            ready_en <= 1'b0;
            asm_full <= 1'b0;
            asm_drop <= 1'b0;
            asm_data <= '0;
            asm_cnt  <= '0;
        end else begin
            ready_en <= 1'b1;
            if (move) begin
                asm_full <= 1'b0;
                asm_data <= '0;
                asm_cnt  <= '0;
            end else if (beat) begin
                if (asm_drop) begin
                    if (s00_axis_tlast) asm_drop <= 1'b0;
                end else if (asm_cnt == 3'd5) begin
                    asm_data <= '0;
                    asm_cnt  <= '0;
                    asm_drop <= ~s00_axis_tlast;
                end else begin
                    for (int k = 0; k < 5; k++) begin
                        if (asm_cnt == 3'(k)) asm_data[8*k +: 8] <= s00_axis_tdata;
                    end
                    asm_cnt <= asm_cnt + 3'd1;
                    if (s00_axis_tlast) asm_full <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            pend_valid <= 1'b0;
            pend_data  <= '0;
            pend_num   <= '0;
        end else if (move) begin
            pend_valid <= 1'b1;
            pend_data  <= asm_data;
            pend_num   <= asm_cnt;
        end else if (load_tx) begin
            pend_valid <= 1'b0;
        end
    end

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) state <= IDLE;
        else                   state <= state_next;
    end

    always_comb begin
        state_next = state;
        load_tx    = 1'b0;
        fire       = 1'b0;
        done_ok    = 1'b0;
        tmo_hit    = 1'b0;
        case (state)
            IDLE: begin
                if (pend_valid) begin
                    load_tx    = 1'b1;
                    state_next = TRIG;
                end
            end
            TRIG: begin
                if (!picc_busy_in) begin
                    fire       = 1'b1;
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (picc_done_in) begin
                    done_ok    = 1'b1;
                    state_next = GUARD;
                end else if (tmo_cnt == '0) begin
                    tmo_hit    = 1'b1;
                    state_next = GUARD;
                end
            end
            GUARD: begin
                if (grd_cnt == '0) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            tmo_cnt            <= '0;
            grd_cnt            <= '0;
            picc_data_out      <= '0;
            picc_num_bytes_out <= '0;
            frames_sent        <= '0;
            err_overlen        <= 1'b0;
            err_timeout        <= 1'b0;
        end else begin
            if (fire)
                tmo_cnt <= TIMEOUT_LOAD;
            else if (state == WAIT_DONE && tmo_cnt != '0)
                tmo_cnt <= tmo_cnt - TW'(1);

            if (done_ok || tmo_hit)
                grd_cnt <= GUARD_LOAD;
            else if (state == GUARD && grd_cnt != '0)
                grd_cnt <= grd_cnt - GW'(1);

            if (load_tx) begin
                picc_data_out      <= pend_data;
                picc_num_bytes_out <= pend_num;
            end

            if (done_ok) frames_sent <= frames_sent + 16'd1;

            // a set in the same cycle as a clear wins
            err_overlen <= overlen_hit | (err_overlen & ~err_clear);
            err_timeout <= tmo_hit     | (err_timeout & ~err_clear);
        end
    end

endmodule

// File: tb/tb_picc_tx_scheduler.sv
// Directed bench for picc_tx_scheduler: a timestamp-based transaction model checked every cycle,
// plus hand-computed literal checks for latency, spacing, errors and reset behaviour.
module tb_picc_tx_scheduler;

    localparam int G  = 4;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s00_axis_tvalid = 1'b0;
    logic [7:0]  s00_axis_tdata = 8'h00;
    logic        s00_axis_tlast = 1'b0;
    logic        s00_axis_tready;
    logic [39:0] picc_data_out;
    logic [2:0]  picc_num_bytes_out;
    logic        picc_trigger_out;
    logic        picc_busy_in = 1'b0;
    logic        picc_done_in = 1'b0;
    logic        tx_active;
    logic [15:0] frames_sent;
    logic        err_overlen;
    logic        err_timeout;
    logic        err_clear = 1'b0;

    picc_tx_scheduler #(.GUARD_CYCLES(G), .TIMEOUT_CYCLES(TO)) dut (
        .s00_axis_aclk      (clk),
        .s00_axis_aresetn   (rst_n),
        .s00_axis_tvalid    (s00_axis_tvalid),
        .s00_axis_tdata     (s00_axis_tdata),
        .s00_axis_tlast     (s00_axis_tlast),
        .s00_axis_tready    (s00_axis_tready),
        .picc_data_out      (picc_data_out),
        .picc_num_bytes_out (picc_num_bytes_out),
        .picc_trigger_out   (picc_trigger_out),
        .picc_busy_in       (picc_busy_in),
        .picc_done_in       (picc_done_in),
        .tx_active          (tx_active),
        .frames_sent        (frames_sent),
        .err_overlen        (err_overlen),
        .err_timeout        (err_timeout),
        .err_clear          (err_clear)
    );

    initial forever #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int hs_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Model: queues for buffered frames, timestamps for the transmit sequence.
    logic [7:0]  m_asm[$];
    bit          m_ready = 0, m_full = 0, m_drop = 0, m_pv = 0;
    logic [39:0] m_pd = '0, m_txd = '0;
    logic [2:0]  m_pn = '0, m_txn = '0;
    bit          m_wtrig = 0, m_wdone = 0;
    int          m_tcyc = 0, m_idle_at = 0;
    logic [15:0] m_frames = '0;
    bit          m_eo = 0, m_et = 0;

    function automatic logic [39:0] pack_asm();
        logic [39:0] d;
        d = '0;
        for (int k = 0; k < m_asm.size(); k++) d = d | (40'(m_asm[k]) << (8 * k));
        return d;
    endfunction

    task automatic model_reset();
        m_asm.delete();
        m_ready = 0; m_full = 0; m_drop = 0; m_pv = 0;
        m_pd = '0; m_pn = '0; m_txd = '0; m_txn = '0;
        m_wtrig = 0; m_wdone = 0; m_tcyc = 0; m_idle_at = 0;
        m_frames = '0; m_eo = 0; m_et = 0;
    endtask

    task automatic model_step();
        bit pv0, full0, rdy, eo_set, et_set;
        pv0 = m_pv; full0 = m_full; rdy = m_ready && !m_full;
        eo_set = 0; et_set = 0;
        if (m_wtrig) begin
            if (!picc_busy_in) begin m_wtrig = 0; m_wdone = 1; m_tcyc = cyc; end
        end else if (m_wdone) begin
            if (picc_done_in) begin
                m_frames = m_frames + 16'd1; m_wdone = 0; m_idle_at = cyc + 1 + G;
            end else if (cyc - m_tcyc == TO) begin
                et_set = 1; m_wdone = 0; m_idle_at = cyc + 1 + G;
            end
        end else if (cyc >= m_idle_at && pv0) begin
            m_txd = m_pd; m_txn = m_pn; m_pv = 0; m_wtrig = 1;
        end
        if (full0 && !pv0) begin
            m_pv = 1; m_pd = pack_asm(); m_pn = 3'(m_asm.size());
            m_asm.delete(); m_full = 0;
        end else if (s00_axis_tvalid && rdy) begin
            if (m_drop) begin
                if (s00_axis_tlast) m_drop = 0;
            end else if (m_asm.size() == 5) begin
                eo_set = 1; m_asm.delete(); m_drop = !s00_axis_tlast;
            end else begin
                m_asm.push_back(s00_axis_tdata);
                if (s00_axis_tlast) m_full = 1;
            end
        end
        m_eo = eo_set || (m_eo && !err_clear);
        m_et = et_set || (m_et && !err_clear);
        m_ready = 1;
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) model_reset();
        else        model_step();
    end

    initial forever begin
        @(negedge clk);
        check("tready",      64'(s00_axis_tready),    64'(m_ready && !m_full));
        check("trigger",     64'(picc_trigger_out),   64'(m_wtrig && !picc_busy_in));
        check("tx_active",   64'(tx_active),          64'(m_wtrig || m_wdone || (cyc < m_idle_at)));
        check("data_out",    64'(picc_data_out),      64'(m_txd));
        check("num_bytes",   64'(picc_num_bytes_out), 64'(m_txn));
        check("frames_sent", 64'(frames_sent),        64'(m_frames));
        check("err_overlen", 64'(err_overlen),        64'(m_eo));
        check("err_timeout", 64'(err_timeout),        64'(m_et));
    end

    task automatic align();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        bit ok;
        ok = 0;
        s00_axis_tvalid = 1'b1; s00_axis_tdata = d; s00_axis_tlast = l;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = s00_axis_tready;
            if (ok) hs_cyc = cyc;
            @(posedge clk);
        end
        #1;
        s00_axis_tvalid = 1'b0; s00_axis_tlast = 1'b0;
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout: byte 0x%0h never accepted, required acceptance within 100 cycles", d);
        end
    endtask

    task automatic wait_trig(output int t);
        t = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (picc_trigger_out) begin t = cyc; break; end
        end
        if (t < 0) begin
            n_cmp++; n_err++;
            $display("FAIL wait_trigger: no trigger seen, required one within 200 cycles");
        end
    endtask

    task automatic done_after(input int k);
        repeat (k) @(posedge clk);
        #1 picc_done_in = 1'b1;
        @(posedge clk);
        #1 picc_done_in = 1'b0;
    endtask

    task automatic clear_pulse();
        align();
        err_clear = 1'b1;
        @(posedge clk);
        #1 err_clear = 1'b0;
    endtask

    task automatic count_trigs(input int n, output int c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (picc_trigger_out) c++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion before 200000 time units");
        $fatal(1);
    end

    initial begin
        int t, n, t0, t1, t2;
        #1;
        check("reset_tready", 64'(s00_axis_tready), 64'(0));
        #11 rst_n = 1'b1;
        #1 check("tready_before_edge", 64'(s00_axis_tready), 64'(0));
        @(negedge clk);
        check("tready_after_edge", 64'(s00_axis_tready), 64'(1));

        // 4-byte frame, latency and data layout
        align();
        send(8'h35, 1'b0); send(8'h67, 1'b0); send(8'h90, 1'b0); send(8'h24, 1'b1);
        n = hs_cyc;
        wait_trig(t);
        check("latency_n_plus_3", 64'(t), 64'(n + 3));
        check("data_4byte", 64'(picc_data_out), 64'h0024906735);
        check("num_4byte", 64'(picc_num_bytes_out), 64'(4));
        done_after(10);
        @(negedge clk);
        check("frames_after_first", 64'(frames_sent), 64'(1));
        repeat (8) @(posedge clk);

        // over-length frame dropped through tlast, next frame clean
        align();
        for (int i = 1; i <= 6; i++) send(8'(i), 1'b0);
        @(negedge clk);
        check("overlen_set", 64'(err_overlen), 64'(1));
        align();
        send(8'hAA, 1'b1);
        count_trigs(10, n);
        check("overlen_no_trigger", 64'(n), 64'(0));
        align();
        send(8'h11, 1'b1);
        wait_trig(t);
        check("data_after_overlen", 64'(picc_data_out), 64'h0000000011);
        check("num_after_overlen", 64'(picc_num_bytes_out), 64'(1));
        done_after(3);
        clear_pulse();
        @(negedge clk);
        check("overlen_cleared", 64'(err_overlen), 64'(0));
        align();
        for (int i = 0; i < 5; i++) send(8'h21 + 8'(i), 1'b0);
        err_clear = 1'b1;
        send(8'h26, 1'b0);
        err_clear = 1'b0;
        @(negedge clk);
        check("overlen_set_beats_clear", 64'(err_overlen), 64'(1));
        align();
        send(8'h27, 1'b1);
        clear_pulse();
        @(negedge clk);
        check("overlen_cleared_again", 64'(err_overlen), 64'(0));
        repeat (12) @(posedge clk);

        // three back-to-back 2-byte frames
        align();
        fork
            begin
                send(8'hA1, 1'b0); send(8'hA2, 1'b1);
                send(8'hB1, 1'b0); send(8'hB2, 1'b1);
                send(8'hC1, 1'b0); send(8'hC2, 1'b1);
                repeat (9) @(negedge clk);
                check("backpressure_third", 64'(s00_axis_tready), 64'(0));
            end
            begin
                wait_trig(t0);
                check("data_frame_a", 64'(picc_data_out), 64'h000000A2A1);
                done_after(10);
                wait_trig(t1);
                check("data_frame_b", 64'(picc_data_out), 64'h000000B2B1);
                done_after(10);
                wait_trig(t2);
                check("data_frame_c", 64'(picc_data_out), 64'h000000C2C1);
                done_after(10);
            end
        join
        check("spacing_ab", 64'(t1 - t0), 64'(16));
        check("spacing_bc", 64'(t2 - t1), 64'(16));
        @(negedge clk);
        check("frames_after_burst", 64'(frames_sent), 64'(5));
        repeat (8) @(posedge clk);

        // transmitter busy holds the trigger
        picc_busy_in = 1'b1;
        align();
        send(8'h5A, 1'b1);
        n = hs_cyc;
        repeat (22) @(posedge clk);
        #1 picc_busy_in = 1'b0;
        wait_trig(t);
        check("trigger_after_busy", 64'(t), 64'(n + 23));
        @(negedge clk);
        check("trigger_one_cycle", 64'(picc_trigger_out), 64'(0));
        done_after(5);
        repeat (8) @(posedge clk);

        // timeout with no done
        align();
        send(8'h77, 1'b1);
        wait_trig(t);
        repeat (16) @(negedge clk);
        check("timeout_not_yet", 64'(err_timeout), 64'(0));
        @(negedge clk);
        check("timeout_set", 64'(err_timeout), 64'(1));
        check("timeout_guard_active", 64'(tx_active), 64'(1));
        check("timeout_frames_same", 64'(frames_sent), 64'(6));
        repeat (4) @(negedge clk);
        check("timeout_back_idle", 64'(tx_active), 64'(0));
        clear_pulse();
        @(negedge clk);
        check("timeout_cleared", 64'(err_timeout), 64'(0));
        repeat (4) @(posedge clk);

        // reset in WAIT_DONE with a frame pending
        align();
        send(8'h81, 1'b1);
        wait_trig(t);
        align();
        send(8'h91, 1'b0); send(8'h92, 1'b1);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("rst_tready", 64'(s00_axis_tready), 64'(0));
        check("rst_trigger", 64'(picc_trigger_out), 64'(0));
        check("rst_tx_active", 64'(tx_active), 64'(0));
        check("rst_data", 64'(picc_data_out), 64'(0));
        check("rst_num", 64'(picc_num_bytes_out), 64'(0));
        check("rst_frames", 64'(frames_sent), 64'(0));
        check("rst_errors", 64'({err_overlen, err_timeout}), 64'(0));
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        fork
            count_trigs(40, n);
            done_after(5);
        join
        check("no_trigger_after_reset", 64'(n), 64'(0));
        check("frames_after_reset", 64'(frames_sent), 64'(0));
        check("idle_after_reset", 64'(tx_active), 64'(0));
        check("tready_after_reset", 64'(s00_axis_tready), 64'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
